// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// - arb_state_e : ownership FSM encoding (IDLE, OWN0, OWN1)
// - P_CPU/P_DMA : requester indices used by the selector and the top level
// - own_state() : maps a port index to its ownership state
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    function automatic arb_state_e own_state(input logic port);
        return (port == P_DMA) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port of the arbiter.
// - req/we/lock/addr/wdata 0/1 : requests into the arbiter
// - gnt/rvalid/rdata/err 0/1   : grant (comb) and registered responses
// - mem_we/mem_a/mem_wd/mem_rd : single-port memory, sync write, async read
// Modports: slave = arbiter side, master = requesters plus memory model.
interface dmem_arbiter_if;

    logic        req0, req1;
    logic        we0, we1;
    logic        lock0, lock1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way selector.
// - req   : {req1, req0}
// - state : current ownership state; an owner that still requests always wins
// - last  : port granted most recently; on a tie the other port wins
// - sel   : selected port index (0 when nobody requests)
// - any   : at least one request present
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_state_e state,
    input  logic       last,
    output logic       sel,
    output logic       any
);

    always_comb begin
        sel = P_CPU;
        any = |req;
        if (state == OWN0 && req[0]) begin
            sel = P_CPU;
        end else if (state == OWN1 && req[1]) begin
            sel = P_DMA;
        end else begin
            // Owner dropped its request (or no owner): plain round-robin.
            unique case (req)
                2'b01:   sel = P_CPU;
                2'b10:   sel = P_DMA;
                2'b11:   sel = ~last;
                default: sel = P_CPU;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the core (port 0)
// and the DMA/test loader (port 1). At most one access per cycle, round-robin
// with an optional bounded burst lock.
// - clk, rst : clock and synchronous active-high reset
// - bus      : requester ports, registered responses and memory port
// Parameters: DEPTH words of memory, MAX_LOCK consecutive locked grants max.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] cnt_eff;

    logic        sel, any;
    logic        gnt_any, gnt0, gnt1;
    logic        we_sel, lock_sel, in_range;
    logic [31:0] addr_sel, wdata_sel;

    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;
    logic        err0_q, err1_q;

    dmem_rr_pick u_pick (
        .req   ({bus.req1, bus.req0}),
        .state (state_q),
        .last  (last_q),
        .sel   (sel),
        .any   (any)
    );

    // Address/data mux; port 0 is presented when nobody requests.
    always_comb begin
        addr_sel  = (sel == P_DMA) ? bus.addr1  : bus.addr0;
        wdata_sel = (sel == P_DMA) ? bus.wdata1 : bus.wdata0;
        we_sel    = (sel == P_DMA) ? bus.we1    : bus.we0;
        lock_sel  = (sel == P_DMA) ? bus.lock1  : bus.lock0;
        in_range  = (addr_sel < 32'(DEPTH));
        gnt_any   = any & ~rst;
        gnt0      = gnt_any & bus.req0 & (sel == P_CPU);
        gnt1      = gnt_any & bus.req1 & (sel == P_DMA);
    end

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    // Out-of-range writes are dropped so the memory never aliases them.
    assign bus.mem_we = gnt_any & we_sel & in_range;
    assign bus.mem_a  = addr_sel;
    assign bus.mem_wd = wdata_sel;

    // Lock count only carries over while the granted port already owns the bus.
    always_comb begin
        state_d    = IDLE;
        lock_cnt_d = '0;
        last_d     = last_q;
        cnt_eff    = (state_q == own_state(sel)) ? lock_cnt_q : '0;
        if (gnt_any) begin
            last_d = sel;
            if (lock_sel && (32'(cnt_eff) < MAX_LOCK - 1)) begin
                state_d    = own_state(sel);
                lock_cnt_d = cnt_eff + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= gnt0 & ~bus.we0;
            rvalid1_q  <= gnt1 & ~bus.we1;
            err0_q     <= gnt0 & ~in_range;
            err1_q     <= gnt1 & ~in_range;
            if (gnt0 && !bus.we0) begin
                rdata0_q <= in_range ? bus.mem_rd : '0;
            end
            if (gnt1 && !bus.we1) begin
                rdata1_q <= in_range ? bus.mem_rd : '0;
            end
        end
    end

    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst;
    logic init_mem;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_LOCK (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: sync write, async read.
    logic [31:0] mem [DEPTH];
    assign bus.mem_rd = (bus.mem_a < 32'(DEPTH)) ? mem[bus.mem_a[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.mem_we && bus.mem_a < 32'(DEPTH)) begin
            mem[bus.mem_a[7:0]] <= bus.mem_wd;
        end
    end

    typedef struct {
        logic        rst, r0, r1, w0, w1, l0, l1;
        logic [31:0] a0, a1, d0, d1;
        logic        g0, g1;
    } vec_t;

    typedef struct {
        logic        rv0, rv1, e0, e1;
        logic [31:0] d0, d1;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        sbq[$];
    logic [31:0] shadow [DEPTH];
    logic [31:0] hold0, hold1;
    int          checks;
    int          failures;

    task automatic add(input logic r, input logic q0, input logic q1, input logic w0,
                       input logic w1, input logic l0, input logic l1, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                       input logic g0, input logic g1);
        vec_t v;
        v.rst = r;  v.r0 = q0; v.r1 = q1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0;  v.a1 = a1; v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        rsp_t r;
        checks   = 0;
        failures = 0;
        hold0    = '0;
        hold1    = '0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = 32'h1000_0000 + 32'(i);

        // Reset with both requesting, then tie alternation.
        add(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 3, 4, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 10, 4, 0, 0, 0, 1);
        // Port 1 writes, port 0 reads back.
        add(0, 0, 1, 0, 1, 0, 0, 0, 5, 0, 32'hDEAD_BEEF, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0);
        // Range: dropped write, word 0 intact, out-of-range read.
        add(0, 1, 0, 1, 0, 0, 0, 256, 0, 32'h1234_5678, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 300, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Same-address write/read serialised: old data first, then new.
        add(0, 1, 1, 1, 0, 0, 0, 7, 7, 32'hCAFE_F00D, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0, 7, 7, 32'hCAFE_F00D, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1);
        // Lock limit: 8 locked grants to port 0, then port 1, then port 0 again.
        for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 0, 1, 0, 20 + i, 9, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0, 28, 9, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0, 28, 11, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0, 29, 11, 0, 0, 1, 0);
        // Reset on the third locked grant, then port 0 wins the tie.
        add(1, 1, 1, 0, 0, 1, 0, 30, 11, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 30, 11, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 11, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        init_mem = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        @(posedge clk);
        #1 init_mem = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            if (sbq.size() > 0) begin
                r = sbq.pop_front();
                chk($sformatf("v%0d rvalid0", i), 32'(bus.rvalid0), 32'(r.rv0));
                chk($sformatf("v%0d rvalid1", i), 32'(bus.rvalid1), 32'(r.rv1));
                chk($sformatf("v%0d err0", i), 32'(bus.err0), 32'(r.e0));
                chk($sformatf("v%0d err1", i), 32'(bus.err1), 32'(r.e1));
                chk($sformatf("v%0d rdata0", i), bus.rdata0, r.d0);
                chk($sformatf("v%0d rdata1", i), bus.rdata1, r.d1);
            end
            rst = v.rst;
            bus.req0 = v.r0;   bus.req1 = v.r1;   bus.we0 = v.w0;   bus.we1 = v.w1;
            bus.lock0 = v.l0;  bus.lock1 = v.l1;  bus.addr0 = v.a0; bus.addr1 = v.a1;
            bus.wdata0 = v.d0; bus.wdata1 = v.d1;
            #1;
            chk($sformatf("v%0d gnt0", i), 32'(bus.gnt0), 32'(v.g0));
            chk($sformatf("v%0d gnt1", i), 32'(bus.gnt1), 32'(v.g1));
            chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we),
                32'((v.g0 & v.w0 & (v.a0 < 32'(DEPTH))) | (v.g1 & v.w1 & (v.a1 < 32'(DEPTH)))));
            if (!v.rst) chk($sformatf("v%0d mem_a", i), bus.mem_a, v.g1 ? v.a1 : v.a0);

            // Expected response one cycle later, from the bench's own memory shadow.
            if (v.rst) begin
                r.rv0 = 0; r.rv1 = 0; r.e0 = 0; r.e1 = 0;
                hold0 = '0; hold1 = '0;
            end else begin
                r.rv0 = v.g0 & ~v.w0;
                r.rv1 = v.g1 & ~v.w1;
                r.e0  = v.g0 & (v.a0 >= 32'(DEPTH));
                r.e1  = v.g1 & (v.a1 >= 32'(DEPTH));
                if (r.rv0) hold0 = (v.a0 < 32'(DEPTH)) ? shadow[v.a0[7:0]] : 32'h0;
                if (r.rv1) hold1 = (v.a1 < 32'(DEPTH)) ? shadow[v.a1[7:0]] : 32'h0;
                if (v.g0 && v.w0 && v.a0 < 32'(DEPTH)) shadow[v.a0[7:0]] = v.d0;
                if (v.g1 && v.w1 && v.a1 < 32'(DEPTH)) shadow[v.a1[7:0]] = v.d1;
            end
            r.d0 = hold0;
            r.d1 = hold1;
            sbq.push_back(r);
        end

        // Drain the last response, then inspect the memory directly.
        @(negedge clk);
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            chk("final rvalid0", 32'(bus.rvalid0), 32'(r.rv0));
            chk("final rvalid1", 32'(bus.rvalid1), 32'(r.rv1));
        end
        chk("mem word0 untouched", mem[0], 32'h1000_0000);
        chk("mem word5 written", mem[5], 32'hDEAD_BEEF);
        chk("mem word7 written", mem[7], 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
